// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder (slave) with all SPI pins oversampled in clk.
// MOSI is deserialised into rx_data; tx_buf is serialised onto miso.
// Optional feature macro: SPI_LSB_FIRST_EN (LSB-first in both directions).
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   sclk, cs_n      SPI clock (idles low) and active-low chip select
//   mosi, miso      serial data in / out (miso is 0 outside a transfer)
//   tx_data/tx_load parallel word to transmit, loaded into tx_buf on tx_load
//   rx_data         last complete received word
//   rx_valid        one-clk pulse when rx_data was updated
//   busy            high while a transfer is active
module spi_responder #(
    parameter int unsigned width       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [width-1:0] tx_data,
    input  logic             tx_load,
    output logic [width-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(width);
`ifdef SPI_LSB_FIRST_EN
    localparam int unsigned TX_BIT = 0;
`else
    localparam int unsigned TX_BIT = width - 1;
`endif

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // Input synchronisers and previous-value registers for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_n_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_n_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_n_prev_q <= cs_n_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;

    // Datapath and control registers
    logic [0:0]       state_q, state_d;
    logic [width-1:0] tx_buf_q, tx_buf_d;
    logic [width-1:0] tx_sh_q, tx_sh_d;
    logic [width-2:0] rx_sh_q, rx_sh_d;   // bits received so far (word minus newest bit)
    logic [width-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             miso_q, miso_d;
    logic             busy_q, busy_d;

    logic [width-1:0] rx_word;
    logic [width-1:0] tx_shifted;

`ifdef SPI_LSB_FIRST_EN
    assign rx_word    = {mosi_s, rx_sh_q};
    assign tx_shifted = {1'b0, tx_sh_q[width-1:1]};
`else
    assign rx_word    = {rx_sh_q, mosi_s};
    assign tx_shifted = {tx_sh_q[width-2:0], 1'b0};
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_load ? tx_data : tx_buf_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d   = S_ACTIVE;
                    tx_sh_d   = tx_buf_q;
                    bit_cnt_d = '0;
                end
            end
            S_ACTIVE: begin
                // cs_n rise has priority over any coincident sclk edge
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sclk_rise) begin
`ifdef SPI_LSB_FIRST_EN
                    rx_sh_d = rx_word[width-1:1];
`else
                    rx_sh_d = rx_word[width-2:0];
`endif
                    if (bit_cnt_q == CNT_W'(width - 1)) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_sh_d    = tx_buf_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall && (bit_cnt_q != '0)) begin
                    // bit_cnt==0 here means the fall after a reload: keep the new first bit
                    tx_sh_d = tx_shifted;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ACTIVE);
        miso_d = busy_d ? tx_sh_d[TX_BIT] : 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_buf_q   <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_buf_q   <= tx_buf_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed bench for spi_responder (width=8, SYNC_STAGES=2,
// sclk half-period 4 clk). Build with SPI_LSB_FIRST_EN to run the LSB-first case.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    int         pulse_cnt = 0;
    int         wide_pulse_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] cap_q[$];

    spi_responder #(.width(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Record every rx_valid pulse and flag any pulse longer than one clk
    always @(negedge clk) begin
        if (rx_valid) begin
            pulse_cnt = pulse_cnt + 1;
            cap_q.push_back(rx_data);
            if (prev_valid) wide_pulse_cnt = wide_pulse_cnt + 1;
        end
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_tx(input logic [7:0] val);
        tx_data = val;
        tx_load = 1'b1;
        wait_clks(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_end();
        wait_clks(4);
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    // Shift nbits of mo out on mosi; mi collects miso sampled just before each rise.
    // With do_load set, tx_data=ld is loaded during bit 3.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit do_load,
                            input logic [7:0] ld, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
`ifdef SPI_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            mosi = mo[idx];
            if (do_load && i == 3) begin
                tx_data = ld;
                tx_load = 1'b1;
                wait_clks(1);
                tx_load = 1'b0;
                wait_clks(3);
            end else begin
                wait_clks(4);
            end
            mi[idx] = miso;
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
    endtask

    logic [7:0] mi0, mi1;

    initial begin
        rst_n   = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        wait_clks(3);

        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        wait_clks(3);

`ifdef SPI_LSB_FIRST_EN
        // LSB-first: tx_buf=01, receive 80
        load_tx(8'h01);
        cs_start();
        check("lsb_busy", 32'(busy), 32'h1);
        spi_bits(8'h80, 8, 1'b0, 8'h00, mi0);
        cs_end();
        check("lsb_rx_data", 32'(rx_data), 32'h80);
        check("lsb_miso_word", 32'(mi0), 32'h01);
        check("lsb_miso_first", 32'(mi0[0]), 32'h1);
        check("lsb_pulses", 32'(pulse_cnt), 32'd1);
        check("lsb_busy_end", 32'(busy), 32'h0);
        check("lsb_miso_idle", 32'(miso), 32'h0);
        check("lsb_wide_pulse", 32'(wide_pulse_cnt), 32'd0);
`else
        // 1: single word
        load_tx(8'hA5);
        cs_start();
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_miso_first", 32'(miso), 32'h1);
        spi_bits(8'h3C, 8, 1'b0, 8'h00, mi0);
        cs_end();
        check("t1_rx_data", 32'(rx_data), 32'h3C);
        check("t1_miso_word", 32'(mi0), 32'hA5);
        check("t1_pulses", 32'(pulse_cnt), 32'd1);
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_miso_idle", 32'(miso), 32'h0);

        // 2: back-to-back words, same tx word resent
        load_tx(8'hC3);
        cap_q.delete();
        cs_start();
        spi_bits(8'h81, 8, 1'b0, 8'h00, mi0);
        spi_bits(8'h7E, 8, 1'b0, 8'h00, mi1);
        cs_end();
        check("t2_pulses", 32'(pulse_cnt), 32'd3);
        check("t2_cap_count", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() == 2) begin
            check("t2_rx_word1", 32'(cap_q[0]), 32'h81);
            check("t2_rx_word2", 32'(cap_q[1]), 32'h7E);
        end
        check("t2_miso_word1", 32'(mi0), 32'hC3);
        check("t2_miso_word2", 32'(mi1), 32'hC3);

        // 3: aborted word after 5 bits
        cs_start();
        spi_bits(8'hFF, 5, 1'b0, 8'h00, mi0);
        cs_end();
        check("t3_pulses", 32'(pulse_cnt), 32'd3);
        check("t3_rx_kept", 32'(rx_data), 32'h7E);
        check("t3_busy", 32'(busy), 32'h0);
        cs_start();
        spi_bits(8'h12, 8, 1'b0, 8'h00, mi0);
        cs_end();
        check("t3_rx_next", 32'(rx_data), 32'h12);
        check("t3_pulses_next", 32'(pulse_cnt), 32'd4);

        // 4: reset mid-word; tx_buf clears so the next word sends 00
        cs_start();
        spi_bits(8'hAA, 3, 1'b0, 8'h00, mi0);
        rst_n = 1'b0;
        #2;
        check("t4_rx_data", 32'(rx_data), 32'h00);
        check("t4_rx_valid", 32'(rx_valid), 32'h0);
        check("t4_miso", 32'(miso), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        cs_n = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        cs_start();
        spi_bits(8'h55, 8, 1'b0, 8'h00, mi0);
        cs_end();
        check("t4_rx_next", 32'(rx_data), 32'h55);
        check("t4_miso_next", 32'(mi0), 32'h00);
        check("t4_pulses", 32'(pulse_cnt), 32'd5);

        // 5: tx_load during word 1 affects only word 2
        load_tx(8'hF0);
        cs_start();
        spi_bits(8'h66, 8, 1'b1, 8'h0F, mi0);
        spi_bits(8'h99, 8, 1'b0, 8'h00, mi1);
        cs_end();
        check("t5_miso_word1", 32'(mi0), 32'hF0);
        check("t5_miso_word2", 32'(mi1), 32'h0F);
        check("t5_rx_data", 32'(rx_data), 32'h99);
        check("t5_wide_pulse", 32'(wide_pulse_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
